// File: rtl/float_pack.sv
// float_pack: shared definitions for the floating-point coprocessor.
//   - float      : internal reduced format {sign, Ne-bit exponent, Nm-bit mantissa}, no
//                  denormals, no inf/NaN; exponent 0 encodes zero
//   - float_ieee : IEEE-754 single-precision layout
//   - conversion : to_float (IEEE -> internal), to_ieee (internal -> IEEE)
//   - arithmetic : float_add, float_sub, float_mul (truncating, saturating)
//   - copro_op_t / copro_state_t : controller opcode and state enums
//   - copro_op_legal : opcode legality; opcodes 3..5 are legal only with FLOAT_COPRO_ACC_EN
package float_pack;

    localparam int Ne      = 7;
    localparam int Nm      = 16;
    localparam int Bias    = (1 << (Ne - 1)) - 1;
    localparam int EmaxInt = (1 << Ne) - 1;
    localparam int Pw      = 2 * Nm + 2;

    typedef struct packed {
        logic          sign;
        logic [Ne-1:0] exp;
        logic [Nm-1:0] mant;
    } float;

    typedef struct packed {
        logic        sign;
        logic [7:0]  exp;
        logic [22:0] mant;
    } float_ieee;

    typedef enum logic [2:0] {
        OpAdd    = 3'd0,
        OpSub    = 3'd1,
        OpMul    = 3'd2,
        OpAccAdd = 3'd3,
        OpAccRd  = 3'd4,
        OpAccClr = 3'd5
    } copro_op_t;

    typedef enum logic [1:0] {
        CoproIdle = 2'd0,
        CoproExec = 2'd1,
        CoproDone = 2'd2
    } copro_state_t;

    localparam float FloatMax = {1'b0, {Ne{1'b1}}, {Nm{1'b1}}};

    function automatic logic copro_op_legal(logic [10:0] opcode);
        if (opcode[10:3] != 8'd0) return 1'b0;
`ifdef FLOAT_COPRO_ACC_EN
        return opcode[2:0] <= 3'd5;
`else
        return opcode[2:0] <= 3'd2;
`endif
    endfunction

    // Denormals and values below the smallest internal normal flush to zero; values beyond
    // the internal range (and inf/NaN) saturate to the largest finite value, sign kept.
    function automatic float to_float(float_ieee x);
        float r;
        int   e;
        r = '0;
        e = int'(x.exp) - 127 + Bias;
        if (x.exp == 8'd0) begin
            r = '0;
        end else if (x.exp == 8'hff || e > EmaxInt) begin
            r      = FloatMax;
            r.sign = x.sign;
        end else if (e > 0) begin
            r.sign = x.sign;
            r.exp  = Ne'(e);
            r.mant = x.mant[22 -: Nm];
        end
        return r;
    endfunction

    function automatic float_ieee to_ieee(float x);
        float_ieee r;
        r = '0;
        if (x.exp != '0) begin
            r.sign = x.sign;
            r.exp  = 8'(int'(x.exp) - Bias + 127);
            r.mant = {x.mant, {(23 - Nm){1'b0}}};
        end
        return r;
    endfunction

    function automatic float float_add(float a, float b);
        float          hi, lo, r;
        logic [Nm+1:0] sig_hi, sig_lo, sum;
        int            e;
        r = '0;
        if (a.exp == '0) return b;
        if (b.exp == '0) return a;
        if ({a.exp, a.mant} >= {b.exp, b.mant}) begin
            hi = a;
            lo = b;
        end else begin
            hi = b;
            lo = a;
        end
        e      = int'(hi.exp);
        sig_hi = {2'b01, hi.mant};
        sig_lo = {2'b01, lo.mant} >> (hi.exp - lo.exp);
        if (hi.sign == lo.sign) begin
            sum = sig_hi + sig_lo;
            if (sum[Nm+1]) begin
                sum = sum >> 1;
                e   = e + 1;
            end
        end else begin
            sum = sig_hi - sig_lo;
            if (sum == '0) return '0;
            // Renormalise: at most Nm left shifts bring the leading one to bit Nm.
            for (int i = 0; i < Nm; i++) begin
                if (!sum[Nm]) begin
                    sum = sum << 1;
                    e   = e - 1;
                end
            end
        end
        if (e > EmaxInt) begin
            r      = FloatMax;
            r.sign = hi.sign;
        end else if (e > 0) begin
            r.sign = hi.sign;
            r.exp  = Ne'(e);
            r.mant = sum[Nm-1:0];
        end
        return r;
    endfunction

    function automatic float float_sub(float a, float b);
        float nb;
        nb = b;
        if (b.exp != '0) nb.sign = ~b.sign;
        return float_add(a, nb);
    endfunction

    function automatic float float_mul(float a, float b);
        float          r;
        logic [Pw-1:0] p;
        int            e;
        r = '0;
        if (a.exp == '0 || b.exp == '0) return '0;
        p = Pw'({1'b1, a.mant}) * Pw'({1'b1, b.mant});
        e = int'(a.exp) + int'(b.exp) - Bias;
        if (p[Pw-1]) begin
            e      = e + 1;
            r.mant = p[Pw-2 -: Nm];
        end else begin
            r.mant = p[Pw-3 -: Nm];
        end
        if (e > EmaxInt) begin
            r      = FloatMax;
            r.sign = a.sign ^ b.sign;
        end else if (e > 0) begin
            r.sign = a.sign ^ b.sign;
            r.exp  = Ne'(e);
        end else begin
            r = '0;
        end
        return r;
    endfunction

endpackage

// File: rtl/float_exec_unit.sv
// float_exec_unit: shared add/sub/mul datapath followed by an EXEC_LAT-deep register pipe.
//   clk, reset : clock and synchronous active-high reset
//   op         : operation select (controller opcode)
//   a, b       : internal-format operands
//   result     : operation result, EXEC_LAT clock edges after the operands were presented
module float_exec_unit
    import float_pack::*;
#(
    parameter int unsigned EXEC_LAT = 2
) (
    input  logic      clk,
    input  logic      reset,
    input  copro_op_t op,
    input  float      a,
    input  float      b,
    output float      result
);

    float stage_d;
    float pipe_q [EXEC_LAT];

    always_comb begin
        stage_d = '0;
        unique case (op)
            OpAdd:    stage_d = float_add(a, b);
            OpSub:    stage_d = float_sub(a, b);
            OpMul:    stage_d = float_mul(a, b);
`ifdef FLOAT_COPRO_ACC_EN
            OpAccAdd: stage_d = float_add(a, b);
            OpAccRd:  stage_d = a;
`endif
            default:  stage_d = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < int'(EXEC_LAT); i++) pipe_q[i] <= '0;
        end else begin
            pipe_q[0] <= stage_d;
            for (int i = 1; i < int'(EXEC_LAT); i++) pipe_q[i] <= pipe_q[i-1];
        end
    end

    assign result = pipe_q[EXEC_LAT-1];

endmodule

// File: rtl/float_copro_ctrl.sv
// float_copro_ctrl: sequencing controller between the LM32 user-instruction port and the
// floating-point execution unit. Optional accumulator opcodes under FLOAT_COPRO_ACC_EN.
//   clk, reset       : clock and synchronous active-high reset
//   user_valid       : request valid, held until user_complete
//   user_opcode      : [2:0] operation, [10:3] must be zero
//   user_operand_0/1 : IEEE single operands A and B
//   user_result      : IEEE single result, held until the next completion
//   user_complete    : one-cycle completion pulse
//   busy             : high outside IDLE
//   illegal_op       : sticky illegal-opcode flag, cleared only by reset
module float_copro_ctrl
    import float_pack::*;
#(
    parameter int unsigned EXEC_LAT = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        user_valid,
    input  logic [10:0] user_opcode,
    input  logic [31:0] user_operand_0,
    input  logic [31:0] user_operand_1,
    output logic [31:0] user_result,
    output logic        user_complete,
    output logic        busy,
    output logic        illegal_op
);

    localparam int unsigned     CntW    = $clog2(EXEC_LAT + 1);
    localparam logic [CntW-1:0] CntLoad = CntW'(EXEC_LAT - 1);

    localparam logic [1:0] StIdle = 2'(CoproIdle);
    localparam logic [1:0] StExec = 2'(CoproExec);
    localparam logic [1:0] StDone = 2'(CoproDone);

    logic [1:0]      state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    float            op_a_q, op_a_d;
    float            op_b_q, op_b_d;
    copro_op_t       opcode_q, opcode_d;
    logic [31:0]     result_q, result_d;
    logic            illegal_q, illegal_d;

    float unit_a, unit_b, exec_result;
    logic exec_last;

    assign exec_last = (state_q == StExec) && (cnt_q == '0);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        op_a_d    = op_a_q;
        op_b_d    = op_b_q;
        opcode_d  = opcode_q;
        result_d  = result_q;
        illegal_d = illegal_q;
        unique case (state_q)
            StIdle: begin
                if (user_valid) begin
                    if (copro_op_legal(user_opcode)) begin
                        state_d  = StExec;
                        cnt_d    = CntLoad;
                        op_a_d   = to_float(user_operand_0);
                        op_b_d   = to_float(user_operand_1);
                        opcode_d = copro_op_t'(user_opcode[2:0]);
                    end else begin
                        state_d   = StDone;
                        result_d  = '0;
                        illegal_d = 1'b1;
                    end
                end
            end
            StExec: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CntW'(1);
                end else begin
                    state_d  = StDone;
                    result_d = to_ieee(exec_result);
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            op_a_q    <= '0;
            op_b_q    <= '0;
            opcode_q  <= OpAdd;
            result_q  <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            op_a_q    <= op_a_d;
            op_b_q    <= op_b_d;
            opcode_q  <= opcode_d;
            result_q  <= result_d;
            illegal_q <= illegal_d;
        end
    end

`ifdef FLOAT_COPRO_ACC_EN
    float acc_q, acc_d;

    always_comb begin
        acc_d = acc_q;
        if (exec_last) begin
            if (opcode_q == OpAccAdd) acc_d = exec_result;
            else if (opcode_q == OpAccClr) acc_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) acc_q <= '0;
        else       acc_q <= acc_d;
    end

    // The accumulator is stable for the whole EXEC period, so it can stand in for an operand.
    assign unit_a = (opcode_d == OpAccRd)  ? acc_q : op_a_d;
    assign unit_b = (opcode_d == OpAccAdd) ? acc_q : op_b_d;
`else
    assign unit_a = op_a_d;
    assign unit_b = op_b_d;
`endif

    // The unit sees the next-state operand values so its pipe starts on the accepting edge;
    // after EXEC_LAT edges the result is ready exactly when the counter expires.
    float_exec_unit #(
        .EXEC_LAT (EXEC_LAT)
    ) u_exec (
        .clk    (clk),
        .reset  (reset),
        .op     (opcode_d),
        .a      (unit_a),
        .b      (unit_b),
        .result (exec_result)
    );

    assign user_result   = result_q;
    assign user_complete = (state_q == StDone);
    assign busy          = (state_q != StIdle);
    assign illegal_op    = illegal_q;

endmodule

// File: tb/tb_float_copro_ctrl.sv
// Self-checking bench for float_copro_ctrl. Expected results come from a real-number model of
// the internal format: 17 significant bits (truncated), smallest normal 2^-62, largest value
// (2 - 2^-16) * 2^64. Accumulator checks are compiled when FLOAT_COPRO_ACC_EN is defined.
module tb_float_copro_ctrl;

    localparam int unsigned EXEC_LAT = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        user_valid = 1'b0;
    logic [10:0] user_opcode = '0;
    logic [31:0] user_operand_0 = '0;
    logic [31:0] user_operand_1 = '0;
    logic [31:0] user_result;
    logic        user_complete;
    logic        busy;
    logic        illegal_op;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    float_copro_ctrl #(
        .EXEC_LAT (EXEC_LAT)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .user_valid     (user_valid),
        .user_opcode    (user_opcode),
        .user_operand_0 (user_operand_0),
        .user_operand_1 (user_operand_1),
        .user_result    (user_result),
        .user_complete  (user_complete),
        .busy           (busy),
        .illegal_op     (illegal_op)
    );

    // ---------------- reference model ----------------
    function automatic real max_val();
        return (2.0 - 2.0 ** (-16)) * (2.0 ** 64);
    endfunction

    function automatic real ieee_to_real(logic [31:0] b);
        real m, v;
        int  e;
        e = int'(b[30:23]);
        m = real'(b[22:0]) / 8388608.0;
        if (e == 0) v = m * (2.0 ** (-126));
        else        v = (1.0 + m) * (2.0 ** (e - 127));
        return b[31] ? -v : v;
    endfunction

    function automatic real quantize(real r);
        real x;
        int  e;
        bit  s;
        if (r == 0.0) return 0.0;
        s = (r < 0.0);
        x = s ? -r : r;
        if (x < 2.0 ** (-62)) return 0.0;
        if (x >= max_val()) begin
            x = max_val();
        end else begin
            e = 0;
            for (int i = 0; i < 300 && x >= 2.0; i++) begin x = x / 2.0; e++; end
            for (int i = 0; i < 300 && x < 1.0; i++) begin x = x * 2.0; e--; end
            x = $floor(x * 65536.0) / 65536.0 * (2.0 ** e);
        end
        return s ? -x : x;
    endfunction

    function automatic real in_conv(logic [31:0] b);
        if (b[30:23] == 8'hff) return b[31] ? -max_val() : max_val();
        return quantize(ieee_to_real(b));
    endfunction

    function automatic logic [31:0] real_to_ieee(real r);
        logic [63:0] d;
        int          e;
        if (r == 0.0) return 32'h0;
        d = $realtobits(r);
        e = int'(d[62:52]) - 1023 + 127;
        return {d[63], 8'(e), d[51:29]};
    endfunction

    function automatic logic [31:0] model_arith(int op, logic [31:0] a, logic [31:0] b);
        real qa, qb, r;
        qa = in_conv(a);
        qb = in_conv(b);
        case (op)
            0:       r = qa + qb;
            1:       r = qa - qb;
            default: r = qa * qb;
        endcase
        return real_to_ieee(quantize(r));
    endfunction

    function automatic logic [31:0] gen_value(int kmin, int kmax);
        real v;
        int  k;
        k = int'($urandom_range(kmax - kmin)) + kmin;
        v = real'($urandom_range(127, 1)) * (2.0 ** k);
        if ($urandom_range(1)) v = -v;
        return real_to_ieee(v);
    endfunction

    // ---------------- stimulus ----------------
    // lat counts cycles with the request cycle as 1; bc counts busy cycles up to completion.
    task automatic issue(input logic [10:0] opc, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] res, output int lat, output int bc);
        bit got;
        got = 0;
        lat = 0;
        bc  = 0;
        res = 32'hdeadbeef;
        @(posedge clk); #1;
        user_valid     = 1'b1;
        user_opcode    = opc;
        user_operand_0 = a;
        user_operand_1 = b;
        for (int n = 1; n <= int'(EXEC_LAT) + 10 && !got; n++) begin
            @(negedge clk);
            if (busy) bc++;
            if (user_complete) begin
                got = 1;
                lat = n;
                res = user_result;
            end
        end
        @(posedge clk); #1;
        user_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        n_checks += 4;
        if (user_result !== 32'h0) begin n_fail++; $display("FAIL reset_result got %h want 0", user_result); end
        if (user_complete !== 1'b0) begin n_fail++; $display("FAIL reset_complete got %b want 0", user_complete); end
        if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
        if (illegal_op !== 1'b0) begin n_fail++; $display("FAIL reset_illegal got %b want 0", illegal_op); end
    endtask

    task automatic test_basic_ops();
        logic [31:0] res;
        int lat, bc;
        issue(11'd0, 32'h3FC00000, 32'h40100000, res, lat, bc);
        n_checks += 3;
        if (res !== 32'h40700000) begin n_fail++; $display("FAIL add_result got %h want 40700000", res); end
        if (lat != int'(EXEC_LAT) + 2) begin n_fail++; $display("FAIL add_latency got %0d want %0d", lat, EXEC_LAT + 2); end
        if (bc != int'(EXEC_LAT) + 1) begin n_fail++; $display("FAIL add_busy got %0d want %0d", bc, EXEC_LAT + 1); end
        issue(11'd2, 32'h40400000, 32'hC0000000, res, lat, bc);
        n_checks++;
        if (res !== 32'hC0C00000) begin n_fail++; $display("FAIL mul_result got %h want c0c00000", res); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] res;
        int lat, bc;
        issue(11'd1, 32'h3F800000, 32'h3F800000, res, lat, bc);
        n_checks++;
        if (res !== 32'h0) begin n_fail++; $display("FAIL sub_zero got %h want 0", res); end
        issue(11'd0, 32'h40400000, 32'h3F800000, res, lat, bc);
        n_checks += 2;
        if (res !== 32'h40800000) begin n_fail++; $display("FAIL b2b_result got %h want 40800000", res); end
        if (lat != int'(EXEC_LAT) + 2) begin n_fail++; $display("FAIL b2b_latency got %0d want %0d", lat, EXEC_LAT + 2); end
    endtask

    task automatic test_boundaries();
        logic [31:0] res, exp_v;
        int lat, bc;
        logic [31:0] av [5] = '{32'h7F000000, 32'hFF800000, 32'h1F800000, 32'h20800000, 32'h3F800001};
        string       nm [5] = '{"sat_pos", "sat_neg_inf", "flush", "min_normal", "trunc"};
        for (int i = 0; i < 5; i++) begin
            exp_v = model_arith(0, av[i], 32'h0);
            issue(11'd0, av[i], 32'h0, res, lat, bc);
            n_checks++;
            if (res !== exp_v) begin n_fail++; $display("FAIL %s got %h want %h", nm[i], res, exp_v); end
        end
    endtask

    task automatic test_random_arith();
        logic [31:0] a, b, res, exp_v;
        int lat, bc, op;
        for (int i = 0; i < 40; i++) begin
            op    = int'($urandom_range(2));
            a     = gen_value(-4, 3);
            b     = gen_value(-4, 3);
            exp_v = model_arith(op, a, b);
            issue(11'(op), a, b, res, lat, bc);
            n_checks += 2;
            if (res !== exp_v) begin n_fail++; $display("FAIL rand_op%0d %h,%h got %h want %h", op, a, b, res, exp_v); end
            if (lat != int'(EXEC_LAT) + 2) begin n_fail++; $display("FAIL rand_latency got %0d want %0d", lat, EXEC_LAT + 2); end
        end
        n_checks++;
        if (illegal_op !== 1'b0) begin n_fail++; $display("FAIL illegal_clear got %b want 0", illegal_op); end
    endtask

    task automatic test_illegal();
        logic [31:0] res;
        int lat, bc;
        logic [10:0] opcs [3] = '{11'd7, 11'd6, 11'h008};
        for (int i = 0; i < 3; i++) begin
            issue(opcs[i], 32'h3F800000, 32'h3F800000, res, lat, bc);
            n_checks += 3;
            if (res !== 32'h0) begin n_fail++; $display("FAIL illegal_result op %h got %h want 0", opcs[i], res); end
            if (lat != 2) begin n_fail++; $display("FAIL illegal_latency op %h got %0d want 2", opcs[i], lat); end
            if (illegal_op !== 1'b1) begin n_fail++; $display("FAIL illegal_flag op %h got %b want 1", opcs[i], illegal_op); end
        end
        issue(11'd0, 32'h3F800000, 32'h3F800000, res, lat, bc);
        n_checks += 2;
        if (res !== 32'h40000000) begin n_fail++; $display("FAIL post_illegal_add got %h want 40000000", res); end
        if (illegal_op !== 1'b1) begin n_fail++; $display("FAIL illegal_sticky got %b want 1", illegal_op); end
    endtask

    task automatic test_accumulator();
        logic [31:0] res, a, exp_v;
        int lat, bc, op;
`ifdef FLOAT_COPRO_ACC_EN
        real acc;
        issue(11'd5, 32'h0, 32'h0, res, lat, bc);
        for (int i = 0; i < 3; i++) issue(11'd3, 32'h3F800000, 32'h0, res, lat, bc);
        issue(11'd4, 32'h0, 32'h0, res, lat, bc);
        n_checks += 2;
        if (res !== 32'h40400000) begin n_fail++; $display("FAIL accrd_result got %h want 40400000", res); end
        if (lat != int'(EXEC_LAT) + 2) begin n_fail++; $display("FAIL accrd_latency got %0d want %0d", lat, EXEC_LAT + 2); end
        acc = 3.0;
        for (int i = 0; i < 15; i++) begin
            op = 3 + int'($urandom_range(2));
            a  = gen_value(-2, 3);
            if (op == 3) acc = quantize(acc + in_conv(a));
            else if (op == 5) acc = 0.0;
            exp_v = real_to_ieee(acc);
            issue(11'(op), a, 32'h0, res, lat, bc);
            n_checks++;
            if (res !== exp_v) begin n_fail++; $display("FAIL acc_op%0d %h got %h want %h", op, a, res, exp_v); end
        end
`else
        for (int i = 3; i <= 5; i++) begin
            op = i;
            a  = gen_value(-2, 3);
            issue(11'(op), a, 32'h0, res, lat, bc);
            n_checks += 2;
            if (res !== 32'h0) begin n_fail++; $display("FAIL noacc_result op %0d got %h want 0", op, res); end
            if (lat != 2) begin n_fail++; $display("FAIL noacc_latency op %0d got %0d want 2", op, lat); end
        end
        exp_v = 32'h0;
`endif
    endtask

    task automatic test_reset_in_exec();
        logic [31:0] res;
        int lat, bc;
        bit seen;
        seen = 0;
        @(posedge clk); #1;
        user_valid     = 1'b1;
        user_opcode    = 11'd0;
        user_operand_0 = 32'h40400000;
        user_operand_1 = 32'h40400000;
        @(posedge clk); #1;
        n_checks++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL rst_exec_busy got %b want 1", busy); end
        reset      = 1'b1;
        user_valid = 1'b0;
        @(negedge clk);
        if (user_complete) seen = 1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        n_checks += 4;
        if (user_result !== 32'h0) begin n_fail++; $display("FAIL rst_exec_result got %h want 0", user_result); end
        if (user_complete !== 1'b0) begin n_fail++; $display("FAIL rst_exec_complete got %b want 0", user_complete); end
        if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_exec_idle_busy got %b want 0", busy); end
        if (illegal_op !== 1'b0) begin n_fail++; $display("FAIL rst_exec_illegal got %b want 0", illegal_op); end
        for (int i = 0; i < int'(EXEC_LAT) + 4; i++) begin
            @(negedge clk);
            if (user_complete) seen = 1;
        end
        n_checks++;
        if (seen) begin n_fail++; $display("FAIL rst_exec_no_pulse got 1 want 0"); end
        issue(11'd0, 32'h3FC00000, 32'h40100000, res, lat, bc);
        n_checks += 2;
        if (res !== 32'h40700000) begin n_fail++; $display("FAIL rst_exec_next_add got %h want 40700000", res); end
        if (lat != int'(EXEC_LAT) + 2) begin n_fail++; $display("FAIL rst_exec_next_lat got %0d want %0d", lat, EXEC_LAT + 2); end
    endtask

    initial begin
        test_reset();
        test_basic_ops();
        test_back_to_back();
        test_boundaries();
        test_random_arith();
        test_illegal();
        test_accumulator();
        test_reset_in_exec();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
